// File: rtl/mine_pkg.sv
// Shared types and constants for the mine placement sequencer.
package mine_pkg;

    localparam int N_CELLS    = 25;
    localparam int IDX_W      = 5;
    localparam int MAX_REJECT = 31;
    localparam int MAX_MINES  = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_GEN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // In a 5-bit context the product keeps only its low 5 bits, which is (mult*x) mod 32.
    function automatic logic [IDX_W-1:0] lcg_next(input logic [IDX_W-1:0] x,
                                                  input logic [IDX_W-1:0] mult,
                                                  input logic [IDX_W-1:0] incr);
        lcg_next = x * mult + incr;
    endfunction

endpackage

// File: rtl/mine_free_pe.sv
// Priority encoder: lowest-index cell that is not occupied.
module mine_free_pe
    import mine_pkg::*;
(
    input  logic [N_CELLS-1:0] i_occ,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        // Scan downwards so the last hit written is the lowest free index.
        for (int i = N_CELLS - 1; i >= 0; i--) begin
            if (!i_occ[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mine_place_ctrl.sv
// Mine placement sequencer: LCG candidates, reject/accept, fallback to lowest free cell.
// Optional safe cell excluded from placement when MINE_SAFE_CELL_EN is defined.
module mine_place_ctrl
    import mine_pkg::*;
(
    input  logic                in_clka,
    input  logic                in_restart,
    input  logic                in_place,
    input  logic [IDX_W-1:0]    in_seed,
    input  logic [IDX_W-1:0]    in_mult,
    input  logic [IDX_W-1:0]    in_incr,
    input  logic [IDX_W-1:0]    in_n_mines,
`ifdef MINE_SAFE_CELL_EN
    input  logic [IDX_W-1:0]    in_safe_cell,
`endif
    output logic [1:0]          out_state,
    output logic                out_busy,
    output logic                out_place_done,
    output logic [N_CELLS-1:0]  out_mines,
    output logic [IDX_W-1:0]    out_temp_index,
    output logic [IDX_W-1:0]    out_temp_mine_cnt,
    output logic                out_clamped
);

    // state | meaning
    // IDLE  | waiting for in_place, mine vector held
    // INIT  | clear board, latch LCG constants and clamped target
    // GEN   | one candidate per cycle until target reached
    // DONE  | one-cycle completion pulse, back to IDLE

    localparam logic [N_CELLS-1:0] ONE_AT_0 = N_CELLS'(1);

    state_t               r_state;
    logic [IDX_W-1:0]     r_x;
    logic [IDX_W-1:0]     r_mult;
    logic [IDX_W-1:0]     r_incr;
    logic [IDX_W-1:0]     r_target;
    logic [IDX_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_rej;
    logic [IDX_W-1:0]     r_temp_index;
    logic [N_CELLS-1:0]   r_mines;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_clamped;

    logic [N_CELLS-1:0]   w_safe_mask;
    logic                 w_safe_ok;
    logic [N_CELLS-1:0]   w_occ;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_free_valid;
    logic [IDX_W-1:0]     w_raw;
    logic [IDX_W-1:0]     w_cand;
    logic [N_CELLS-1:0]   w_cand_onehot;
    logic                 w_accept;
    logic [IDX_W-1:0]     w_target_in;
    logic                 w_clamp_in;

`ifdef MINE_SAFE_CELL_EN
    logic [IDX_W-1:0]     r_safe;

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_safe <= '0;
        end else if (r_state == ST_INIT) begin
            r_safe <= in_safe_cell;
        end
    end

    // An out-of-board safe index shifts the one out, leaving an empty mask.
    assign w_safe_mask = ONE_AT_0 << r_safe;
    assign w_safe_ok   = (w_cand != r_safe);
`else
    assign w_safe_mask = '0;
    assign w_safe_ok   = 1'b1;
`endif

    assign w_occ = r_mines | w_safe_mask;

    mine_free_pe u_free_pe (
        .i_occ   (w_occ),
        .o_idx   (w_free_idx),
        .o_valid (w_free_valid)
    );

    assign w_raw         = lcg_next(r_x, r_mult, r_incr);
    assign w_cand        = ((r_rej == IDX_W'(MAX_REJECT)) && w_free_valid) ? w_free_idx : w_raw;
    assign w_cand_onehot = ONE_AT_0 << w_cand;
    assign w_accept      = (w_cand < IDX_W'(N_CELLS)) && ((r_mines & w_cand_onehot) == '0) && w_safe_ok;

    assign w_clamp_in  = (in_n_mines > IDX_W'(MAX_MINES));
    assign w_target_in = w_clamp_in ? IDX_W'(MAX_MINES) : in_n_mines;

    always_ff @(posedge in_clka) begin
        if (in_restart) begin
            r_state      <= ST_IDLE;
            r_x          <= '0;
            r_mult       <= '0;
            r_incr       <= '0;
            r_target     <= '0;
            r_cnt        <= '0;
            r_rej        <= '0;
            r_temp_index <= '0;
            r_mines      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_clamped    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (in_place) begin
                        r_state <= ST_INIT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_INIT: begin
                    r_mines   <= '0;
                    r_cnt     <= '0;
                    r_rej     <= '0;
                    r_x       <= in_seed;
                    r_mult    <= in_mult;
                    r_incr    <= in_incr;
                    r_target  <= w_target_in;
                    r_clamped <= w_clamp_in;
                    if (w_target_in == '0) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    r_temp_index <= w_cand;
                    r_x          <= w_cand;
                    if (w_accept) begin
                        r_mines <= r_mines | w_cand_onehot;
                        r_cnt   <= r_cnt + 1'b1;
                        r_rej   <= '0;
                        if (r_cnt + 1'b1 == r_target) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_rej <= r_rej + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_state         = r_state;
    assign out_busy          = r_busy;
    assign out_place_done    = r_done;
    assign out_mines         = r_mines;
    assign out_temp_index    = r_temp_index;
    assign out_temp_mine_cnt = r_cnt;
    assign out_clamped       = r_clamped;

endmodule

// File: tb/tb_mine_place_ctrl.sv
// Self-checking bench for mine_place_ctrl; covers MINE_SAFE_CELL_EN builds as well.
module tb_mine_place_ctrl;

    localparam int BUDGET = 1200;

    logic        in_clka = 1'b0;
    logic        in_restart;
    logic        in_place;
    logic [4:0]  in_seed;
    logic [4:0]  in_mult;
    logic [4:0]  in_incr;
    logic [4:0]  in_n_mines;
`ifdef MINE_SAFE_CELL_EN
    logic [4:0]  in_safe_cell;
`endif
    logic [1:0]  out_state;
    logic        out_busy;
    logic        out_place_done;
    logic [24:0] out_mines;
    logic [4:0]  out_temp_index;
    logic [4:0]  out_temp_mine_cnt;
    logic        out_clamped;

    mine_place_ctrl dut (
        .in_clka           (in_clka),
        .in_restart        (in_restart),
        .in_place          (in_place),
        .in_seed           (in_seed),
        .in_mult           (in_mult),
        .in_incr           (in_incr),
        .in_n_mines        (in_n_mines),
`ifdef MINE_SAFE_CELL_EN
        .in_safe_cell      (in_safe_cell),
`endif
        .out_state         (out_state),
        .out_busy          (out_busy),
        .out_place_done    (out_place_done),
        .out_mines         (out_mines),
        .out_temp_index    (out_temp_index),
        .out_temp_mine_cnt (out_temp_mine_cnt),
        .out_clamped       (out_clamped)
    );

    always #5 in_clka = ~in_clka;

    typedef struct {
        logic [4:0]  seed;
        logic [4:0]  mult;
        logic [4:0]  incr;
        logic [4:0]  n;
        logic [4:0]  safe;
        bit          use_model;
        logic [24:0] mines;
        int          lat;
        logic [4:0]  cnt;
        logic        clamped;
        logic [4:0]  last;
        bit          chk_last;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] seed, mult, incr, n, safe, input bit use_model,
                                input logic [24:0] mines, input int lat, input logic [4:0] cnt,
                                input logic clamped, input logic [4:0] last, input bit chk_last);
        vec_t v;
        v.seed = seed; v.mult = mult; v.incr = incr; v.n = n; v.safe = safe;
        v.use_model = use_model; v.mines = mines; v.lat = lat; v.cnt = cnt;
        v.clamped = clamped; v.last = last; v.chk_last = chk_last;
        return v;
    endfunction

    // Behavioural reference of the placement algorithm.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int target, cycles, rej, c;
        logic [4:0] x;
        bit ok;
        target    = (v.n > 24) ? 24 : int'(v.n);
        r.clamped = (v.n > 24);
        r.mines   = '0;
        r.cnt     = '0;
        x = v.seed; rej = 0; cycles = 0;
        while (int'(r.cnt) < target) begin
            if (rej == 31) begin
                c = -1;
                for (int j = 24; j >= 0; j--) begin
                    ok = !r.mines[j];
`ifdef MINE_SAFE_CELL_EN
                    ok = ok && (j != int'(v.safe));
`endif
                    if (ok) c = j;
                end
            end else begin
                c = (int'(v.mult) * int'(x) + int'(v.incr)) % 32;
            end
            cycles++;
            ok = (c >= 0) && (c < 25) && !r.mines[c];
`ifdef MINE_SAFE_CELL_EN
            ok = ok && (c != int'(v.safe));
`endif
            if (ok) begin
                r.mines[c] = 1'b1;
                r.cnt      = r.cnt + 5'd1;
                rej        = 0;
            end else begin
                rej++;
            end
            x = 5'(c);
        end
        r.lat      = 2 + cycles;
        r.last     = x;
        r.chk_last = (target > 0);
        return r;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(out_state), 0);
        chk({tag, "_mines"}, 32'(out_mines), 0);
        chk({tag, "_cnt"}, 32'(out_temp_mine_cnt), 0);
        chk({tag, "_tidx"}, 32'(out_temp_index), 0);
        chk({tag, "_busy"}, 32'(out_busy), 0);
        chk({tag, "_done"}, 32'(out_place_done), 0);
        chk({tag, "_clamp"}, 32'(out_clamped), 0);
    endtask

    task automatic run_vec(input int id, input vec_t v);
        vec_t e;
        int   k, busy_cnt;
        bit   seen;
        e = v.use_model ? model(v) : v;
        sb.push_back(e);
        @(negedge in_clka);
        in_seed = v.seed; in_mult = v.mult; in_incr = v.incr; in_n_mines = v.n;
`ifdef MINE_SAFE_CELL_EN
        in_safe_cell = v.safe;
`endif
        in_place = 1'b1;
        @(posedge in_clka);
        k = 1; busy_cnt = 0; seen = 0;
        while (k <= BUDGET) begin
            @(negedge in_clka);
            if (k == 1) chk($sformatf("v%0d_st_init", id), 32'(out_state), 1);
            if (k == 2) chk($sformatf("v%0d_st_k2", id), 32'(out_state), (e.lat == 2) ? 3 : 2);
            if (out_place_done) begin
                seen = 1;
                in_place = 1'b0;
                break;
            end
            if (out_busy) busy_cnt++;
            in_place = (k == 3);
            if (k == 2) begin
                in_seed = 5'($urandom); in_mult = 5'($urandom);
                in_incr = 5'($urandom); in_n_mines = 5'($urandom);
            end
            @(posedge in_clka);
            k++;
        end
        e = sb.pop_front();
        if (!seen) begin
            chk($sformatf("v%0d_done_timeout", id), 0, 1);
            in_place = 1'b0;
            in_restart = 1'b1;
            @(negedge in_clka);
            in_restart = 1'b0;
            return;
        end
        chk($sformatf("v%0d_latency", id), 32'(k), 32'(e.lat));
        chk($sformatf("v%0d_mines", id), 32'(out_mines), 32'(e.mines));
        chk($sformatf("v%0d_cnt", id), 32'(out_temp_mine_cnt), 32'(e.cnt));
        chk($sformatf("v%0d_popcnt", id), 32'($countones(out_mines)), 32'(e.cnt));
        chk($sformatf("v%0d_clamped", id), 32'(out_clamped), 32'(e.clamped));
        chk($sformatf("v%0d_busy_cycles", id), 32'(busy_cnt), 32'(e.lat - 1));
        if (e.chk_last) chk($sformatf("v%0d_last_idx", id), 32'(out_temp_index), 32'(e.last));
        @(negedge in_clka);
        chk($sformatf("v%0d_done_pulse", id), 32'(out_place_done), 0);
        chk($sformatf("v%0d_back_idle", id), 32'(out_state), 0);
        chk($sformatf("v%0d_mines_held", id), 32'(out_mines), 32'(e.mines));
    endtask

    initial begin
        int dones;
        in_restart = 1'b1; in_place = 1'b0;
        in_seed = '0; in_mult = '0; in_incr = '0; in_n_mines = '0;
`ifdef MINE_SAFE_CELL_EN
        in_safe_cell = 5'd31;
`endif
        repeat (2) @(posedge in_clka);
        @(negedge in_clka);
        in_restart = 1'b0;
        chk_reset("reset");

        tbl.push_back(mk(5'd0, 5'd5, 5'd1, 5'd3, 5'd31, 0, 25'h0002042, 7, 5'd3, 1'b0, 5'd13, 1));
        tbl.push_back(mk(5'd0, 5'd8, 5'd13, 5'd3, 5'd31, 0, 25'h0202001, 36, 5'd3, 1'b0, 5'd0, 1));
        tbl.push_back(mk(5'd9, 5'd5, 5'd1, 5'd0, 5'd31, 0, 25'h0, 2, 5'd0, 1'b0, 5'd0, 0));
        tbl.push_back(mk(5'd0, 5'd5, 5'd1, 5'd31, 5'd31, 1, '0, 0, '0, 1'b0, '0, 0));
        tbl.push_back(mk(5'd7, 5'd3, 5'd5, 5'd10, 5'd31, 1, '0, 0, '0, 1'b0, '0, 0));
        tbl.push_back(mk(5'd31, 5'd1, 5'd0, 5'd5, 5'd31, 1, '0, 0, '0, 1'b0, '0, 0));
        tbl.push_back(mk(5'd3, 5'd5, 5'd3, 5'd24, 5'd31, 1, '0, 0, '0, 1'b0, '0, 0));
        tbl.push_back(mk(5'd11, 5'd13, 5'd7, 5'd25, 5'd31, 1, '0, 0, '0, 1'b0, '0, 0));
`ifdef MINE_SAFE_CELL_EN
        tbl.push_back(mk(5'd0, 5'd5, 5'd1, 5'd3, 5'd13, 0, 25'h0000046, 8, 5'd3, 1'b0, 5'd2, 1));
        tbl.push_back(mk(5'd0, 5'd8, 5'd13, 5'd20, 5'd0, 1, '0, 0, '0, 1'b0, '0, 0));
`endif
        foreach (tbl[i]) run_vec(i, tbl[i]);

        // Restart in the middle of GEN for the basic case.
        @(negedge in_clka);
        in_seed = 5'd0; in_mult = 5'd5; in_incr = 5'd1; in_n_mines = 5'd3;
`ifdef MINE_SAFE_CELL_EN
        in_safe_cell = 5'd31;
`endif
        in_place = 1'b1;
        @(posedge in_clka);
        @(negedge in_clka);
        in_place = 1'b0;
        repeat (3) begin
            @(posedge in_clka);
            @(negedge in_clka);
        end
        chk("midgen_state", 32'(out_state), 2);
        in_restart = 1'b1;
        @(posedge in_clka);
        @(negedge in_clka);
        chk_reset("midgen_rst");
        in_restart = 1'b0;
        dones = 0;
        repeat (10) begin
            @(posedge in_clka);
            @(negedge in_clka);
            if (out_place_done) dones++;
        end
        chk("midgen_no_done", 32'(dones), 0);
        chk("midgen_idle", 32'(out_state), 0);
        run_vec(100, tbl[0]);

        // Restart and place together: restart wins.
        @(negedge in_clka);
        in_restart = 1'b1; in_place = 1'b1;
        @(posedge in_clka);
        @(negedge in_clka);
        chk_reset("simul");
        in_restart = 1'b0; in_place = 1'b0;
        @(posedge in_clka);
        @(negedge in_clka);
        chk("simul_stay_idle", 32'(out_state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mine_place_ctrl.md
# mine_place_ctrl

Sequencer for minesweeper mine placement on the 5x5 board. On a place request it drives a 5-bit linear congruential generator (LCG), rejects off-board and duplicate candidates, and sets exactly the requested number of distinct bits in a 25-bit mine vector. A deterministic fallback guarantees termination for degenerate LCG constants. It sits between the main game FSM, which issues the request, and the decode/ALU stages, which consume `out_mines`.

## Interface
- `N_CELLS`, 25, board cells; valid indices are 0..24.
- `IDX_W`, 5, cell index and LCG width.
- `MAX_REJECT`, 31, consecutive rejections before the fallback candidate is used.

- `in_clka` input 1: the single clock. All state updates on its rising edge.
- `in_restart` input 1: reset, synchronous, active-high.
- `in_place` input 1: placement request, sampled only in IDLE.
- `in_seed` input 5: LCG start value, latched in INIT.
- `in_mult` input 5: LCG multiplier, latched in INIT.
- `in_incr` input 5: LCG increment, latched in INIT.
- `in_n_mines` input 5: requested mine count, latched in INIT.
- `in_safe_cell` input 5: cell that must never be mined. Present only with `MINE_SAFE_CELL_EN`.
- `out_state` output 2: current FSM state.
- `out_busy` output 1: high in INIT and GEN.
- `out_place_done` output 1: one-cycle pulse in DONE.
- `out_mines` output 25: mine vector; bit i set means cell i holds a mine.
- `out_temp_index` output 5: last candidate evaluated.
- `out_temp_mine_cnt` output 5: mines placed so far.
- `out_clamped` output 1: the request exceeded 24 and was clamped; held until the next INIT.

## Operation
- **States:** IDLE=0, INIT=1, GEN=2, DONE=3.
- **IDLE:**
  - `in_place`=1 moves to INIT.
  - `out_mines` holds its last value.
- **INIT:** one cycle.
  - Clear `out_mines` and the counters.
  - x ← `in_seed`; latch mult and incr.
  - target ← min(`in_n_mines`, 24); `out_clamped` ← (`in_n_mines` > 24).
  - target = 0 goes to DONE; otherwise go to GEN.
- **GEN:** one candidate per cycle.
  - Raw candidate: c = (mult·x + incr) mod 32, taken as the low 5 bits of the 10-bit product plus incr.
  - If rej == `MAX_REJECT`, c is replaced by the lowest-index free cell.
  - Accept when c < 25 and `out_mines`[c] = 0. With the macro, c ≠ safe cell is also required.
  - On accept: set the bit, cnt+1, rej ← 0.
  - On reject: rej+1.
  - x ← c in both cases, including the fallback case.
  - The state moves to DONE in the cycle after cnt reaches target.
- **DONE:**
  - `out_place_done`=1 for this cycle only.
  - Return to IDLE.
- `in_place` is ignored outside IDLE. Changes to the configuration inputs after INIT have no effect.
- With target ≤ 24, a free cell always exists, so the fallback never finds an empty board.

## Timing
- **Reset values:**
  - state IDLE, `out_state`=0, `out_mines`=0.
  - cnt=0, `out_temp_index`=0.
  - `out_busy`=0, `out_place_done`=0, `out_clamped`=0.
- **Latency:**
  - `in_place` sampled at cycle t gives INIT at t+1 and the first candidate at t+2.
  - With no rejections, `out_place_done` fires at t+2+N.
  - Each rejection adds one cycle.
  - Worst case per mine is `MAX_REJECT`+1 cycles.
- **Zero request:** `in_n_mines`=0 gives `out_place_done` at t+2 with `out_mines`=0.
- **Restart:** `in_restart` in any state, including mid-GEN, returns all outputs to reset values on the next edge. No done pulse is emitted.
- **Simultaneous restart and place:** restart wins.

## Configuration
- `MINE_SAFE_CELL_EN` defined:
  - The `in_safe_cell` port exists and is latched in INIT.
  - That cell is never accepted, and the fallback skips it.
  - The clamp stays at 24; all other cells remain available.
- `MINE_SAFE_CELL_EN` undefined:
  - There is no safe-cell port.
  - Every cell 0..24 is eligible.

## Structure
- **Shared package `mine_pkg`:** state enum, `N_CELLS`, `IDX_W`, `MAX_REJECT`, `MAX_MINES`=24.
- **Sub-module `mine_free_pe`:** combinational priority encoder.
  - Input: the 25-bit occupancy vector (mines OR safe-cell mask).
  - Output: lowest free index plus a valid bit.

## Test plan
- **Basic placement:** seed=0, mult=5, incr=1, n=3. Candidates 1 and 6 accepted; 31 and 28 rejected; 13 accepted. Expected: `out_mines`=0x0002042, done at t+7, cnt=3.
- **Degenerate LCG:** seed=0, mult=8, incr=13, n=3. 13 and 21 accepted, then 21 repeats. After 31 rejections, fallback accepts 0. Expected: `out_mines`=0x0202001, done at t+36.
- **Zero request:** n=0. Expected: done at t+2, `out_mines`=0, `out_busy` high for one cycle.
- **Clamp:** n=31. Expected: `out_clamped`=1, cnt=24, popcount(`out_mines`)=24.
- **Restart mid-GEN:** assert `in_restart` at t+4 of the basic case. Expected: next cycle IDLE, `out_mines`=0, no done pulse. A fresh `in_place` then reproduces 0x0002042.
- **Safe cell:** with `MINE_SAFE_CELL_EN`, safe cell=13 and the basic-placement constants. Expected: 13 rejected, the next candidate 2 accepted, `out_mines`=0x0000046, bit 13 never set.
